// File: rtl/game_score_ctrl.sv
// game_score_ctrl: game flow controller for a side-scrolling bird game.
// Watches the start button, detects bird/barrier collisions in the collision
// column, and keeps a BCD score plus a best-since-reset high score.
// The FSM state is exported directly on `state` so checkers can bind to it.
// Inputs have no handshake: `tick` is a one-cycle pulse sampled on every
// rising edge, and every output is a register updated on that same edge.
module game_score_ctrl #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 4,
  parameter int GRACE  = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bird_col,
  input  logic [WIDTH-1:0]      barrier_col,
  input  logic                  tick,
  output logic                  enable,
  output logic [1:0]            state,
  output logic [4*DIGITS-1:0]   score,
  output logic [4*DIGITS-1:0]   high_score,
  output logic                  game_over,
  output logic                  new_high,
  output logic                  wrapped
);

  localparam int SW = 4 * DIGITS;
  // Grace counter is always at least one bit wide, even when GRACE is 0.
  localparam int GW = (GRACE < 1) ? 1 : $clog2(GRACE + 1);
  localparam logic [GW-1:0] GRACE_C = GW'(GRACE);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_OVER = 2'b10,
    S_BAD  = 2'b11
  } state_t;

  state_t          state_q, state_d;
  logic            start_q;
  logic            enable_q, enable_d;
  logic            game_over_q, game_over_d;
  logic            new_high_q, new_high_d;
  logic            wrapped_q, wrapped_d;
  logic [SW-1:0]   score_q, score_d;
  logic [SW-1:0]   high_q, high_d;
  logic [GW-1:0]   grace_q, grace_d;

  logic            start_edge;
  logic            collision;
  logic            enter_run;
  logic            end_game;
  logic            score_tick;
  logic [SW-1:0]   score_inc;
  logic            inc_carry;

  // Button is active-low: a game starts on a 1->0 transition of start.
  assign start_edge = start_q & ~start;
  assign collision  = |(bird_col & barrier_col);

  // Start button history; cleared on reset so a held button cannot start a game.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) start_q <= 1'b0;
    else        start_q <= start;
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: start always wins in RUN, then collision.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_edge) state_d = S_RUN;
      S_RUN: begin
        if (start_edge)     state_d = S_RUN;
        else if (collision) state_d = S_OVER;
      end
      S_OVER:  if (start_edge) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  // BCD +1 with ripple carry; a digit at 9 (or corrupted above 9) becomes 0.
  always_comb begin
    score_inc = score_q;
    inc_carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (inc_carry) begin
        if (score_q[4*i +: 4] >= 4'd9) begin
          score_inc[4*i +: 4] = 4'd0;
        end else begin
          score_inc[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
          inc_carry = 1'b0;
        end
      end
    end
  end

  // FSM outputs and scoring datapath next values.
  always_comb begin
    enter_run   = start_edge && (state_q != S_BAD);
    end_game    = (state_q == S_RUN) && !start_edge && collision;
    score_tick  = (state_q == S_RUN) && !start_edge && !collision && tick;

    enable_d    = (state_d == S_RUN);
    game_over_d = end_game;
    score_d     = score_q;
    high_d      = high_q;
    grace_d     = grace_q;
    wrapped_d   = wrapped_q;
    new_high_d  = new_high_q;

    if (enter_run) begin
      score_d    = '0;
      grace_d    = '0;
      wrapped_d  = 1'b0;
      new_high_d = 1'b0;
    end else if (end_game) begin
      // Packed BCD compares correctly as a plain unsigned vector.
      if (score_q > high_q) begin
        high_d     = score_q;
        new_high_d = 1'b1;
      end
    end else if (score_tick) begin
      if (grace_q < GRACE_C) begin
        grace_d = grace_q + GW'(1);
      end else begin
        score_d = score_inc;
        if (inc_carry) wrapped_d = 1'b1;
      end
    end
  end

  // Output and datapath registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      enable_q    <= 1'b0;
      game_over_q <= 1'b0;
      new_high_q  <= 1'b0;
      wrapped_q   <= 1'b0;
      score_q     <= '0;
      high_q      <= '0;
      grace_q     <= '0;
    end else begin
      enable_q    <= enable_d;
      game_over_q <= game_over_d;
      new_high_q  <= new_high_d;
      wrapped_q   <= wrapped_d;
      score_q     <= score_d;
      high_q      <= high_d;
      grace_q     <= grace_d;
    end
  end

  assign enable     = enable_q;
  assign state      = state_q;
  assign score      = score_q;
  assign high_score = high_q;
  assign game_over  = game_over_q;
  assign new_high   = new_high_q;
  assign wrapped    = wrapped_q;

endmodule

// File: doc/game_score_ctrl.md
GAME_SCORE_CTRL -- requirements
Module: game_score_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of lanes in the collision column.
REQ-002 SHALL have parameter DIGITS, default 4, number of BCD score digits.
REQ-003 SHALL have parameter GRACE, default 2, number of scoring ticks ignored after each game start.
REQ-004 SHALL have port clock, input, 1, single system clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, active-low start push button, idle high.
REQ-007 SHALL have port bird_col, input, WIDTH, bird occupancy of the collision column.
REQ-008 SHALL have port barrier_col, input, WIDTH, barrier occupancy of the collision column.
REQ-009 SHALL have port tick, input, 1, one-cycle pulse, one per barrier pass.
REQ-010 SHALL have port enable, output, 1, high only in RUN.
REQ-011 SHALL have port state, output, 2, FSM state encoding: IDLE=00, RUN=01, OVER=10.
REQ-012 SHALL have port score, output, 4*DIGITS, BCD score with digit 0 in bits [3:0].
REQ-013 SHALL have port high_score, output, 4*DIGITS, BCD best score since reset.
REQ-014 SHALL have port game_over, output, 1, one-cycle pulse on entry to OVER.
REQ-015 SHALL have port new_high, output, 1, high while in OVER if the last game set a new best.
REQ-016 SHALL have port wrapped, output, 1, sticky flag set when score rolls over from all-9s.

Function
REQ-017 SHALL register start into start_reg every cycle; start_edge = start_reg==1 && start==0, i.e. a falling edge.
REQ-018 SHALL define collision = OR-reduce(bird_col & barrier_col), combinational, evaluated every cycle.
REQ-019 IDLE SHALL transition to RUN on start_edge and otherwise hold; collision and tick SHALL be ignored in IDLE.
REQ-020 On every entry to RUN (from IDLE, from OVER, or restart), the block SHALL clear score, grace_cnt, wrapped and new_high in the same cycle.
REQ-021 RUN + start_edge SHALL restart: the block stays in RUN with the clears of REQ-020; start_edge has priority over collision and tick.
REQ-022 RUN + collision SHALL go to OVER on the next edge; enable SHALL fall with that same edge; game_over SHALL be high for exactly that one following cycle.
REQ-023 RUN + tick + collision in the same cycle: collision wins and score SHALL NOT increment.
REQ-024 RUN + tick with grace_cnt < GRACE SHALL increment grace_cnt (saturating counter, width clog2(GRACE+1), minimum 1) and SHALL leave score unchanged.
REQ-025 RUN + tick with grace_cnt == GRACE SHALL increment score by 1 in BCD: digit 0 +1; any digit at 9 becomes 0 and carries into the next digit; no digit ever exceeds 9.
REQ-026 A score increment from all digits at 9 SHALL wrap every digit to 0 and set wrapped=1; wrapped SHALL then hold until the next entry to RUN.
REQ-027 On the RUN->OVER transition edge, if score > high_score (unsigned BCD compare), the block SHALL load high_score<=score and set new_high<=1; otherwise both SHALL be unchanged.
REQ-028 OVER SHALL hold score and high_score and keep enable=0; start_edge SHALL go to RUN per REQ-020.
REQ-029 State 11 SHALL be unreachable; if ever reached it SHALL return to IDLE on the next edge.
REQ-030 All outputs SHALL be registered; the only latency from input to output SHALL be one clock.

Reset
REQ-031 reset low SHALL immediately and asynchronously force: state=IDLE, start_reg=0, enable=0, score=0, high_score=0, grace_cnt=0, game_over=0, new_high=0, wrapped=0.
REQ-032 Mid-game reset SHALL discard the game, including high_score; on reset release no start_edge SHALL occur while start is held low, because start_reg=0.
REQ-033 The first transition after reset release SHALL require a start 1->0 edge sampled on two consecutive clock edges.

Verification (WIDTH=8, DIGITS=4, GRACE=2)
REQ-034 Start edge, then 5 ticks with no collision: score=0x0003, enable=1, state=01.
REQ-035 score=0x0099 with grace satisfied, then one tick: score=0x0100; then bird_col=barrier_col=8'h10 with a simultaneous tick: score stays 0x0100, one-cycle game_over, state=10, high_score=0x0100, new_high=1.
REQ-036 Second game ending at score=0x0042 while high_score=0x0100: high_score stays 0x0100 and new_high=0.
REQ-037 score preset to 0x9999 in RUN, then one tick: score=0x0000 and wrapped=1; a later start edge clears wrapped to 0.
REQ-038 bird_col=8'h01 with barrier_col=8'hFE: no game over; start held low across reset release: state remains 00 until start goes high then low.
REQ-039 Assert reset mid-RUN at score=0x0007: all outputs read 0 asynchronously, before the next clock edge.
